// File: rtl/mul_iter.sv
// +----------------------------------------------------------------------------
// | mul_iter : iterative shift-add signed/unsigned multiplier, one bit per cycle
// | Option   : MUL_ITER_EARLY_TERM_EN ends BUSY once remaining multiplier bits are 0
// | Revision : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             upper,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic               upper_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod;
  logic               accept;
  logic               last;

  // Negating the most-negative value wraps to itself, which read unsigned is 2^(WIDTH-1).
  assign a_mag   = (sign_a && A[WIDTH-1]) ? -A : A;
  assign b_mag   = (sign_b && B[WIDTH-1]) ? -B : B;
  assign acc_nxt = acc + (b_sh[0] ? a_sh : '0);
  assign prod    = neg ? -acc_nxt : acc_nxt;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef MUL_ITER_EARLY_TERM_EN
  assign last = (cnt == LAST) || (b_sh[WIDTH-1:1] == '0);
`else
  assign last = (cnt == LAST);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      upper_q   <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      // Covers both the idle start and the back-to-back start out of DONE.
      state     <= BUSY;
      acc       <= '0;
      a_sh      <= {{WIDTH{1'b0}}, a_mag};
      b_sh      <= b_mag;
      cnt       <= '0;
      neg       <= (sign_a && A[WIDTH-1]) ^ (sign_b && B[WIDTH-1]);
      upper_q   <= upper;
      out_valid <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
          if (last) begin
            dout      <= upper_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter (WIDTH=32): vector table, random model ops, handshake and reset sequences.
`default_nettype none

module tb_mul_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  A, B;
  logic          sign_a, sign_b, upper;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  dout;
  logic          out_valid;
  logic          out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] sb_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sa;
    logic         sb;
    logic         up;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[12];

  mul_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .upper     (upper),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sa, input logic sb, input logic up);
    logic [2*W-1:0] ea, eb, p;
    ea = sa ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sb ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    return up ? p[2*W-1:W] : p[W-1:0];
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b, input logic sb);
`ifdef MUL_ITER_EARLY_TERM_EN
    logic [W-1:0] m;
    int hi;
    m  = (sb && b[W-1]) ? -b : b;
    hi = 0;
    for (int k = 0; k < W; k++) if (m[k]) hi = k;
    return hi + 1;
`else
    return W;
`endif
  endfunction

  // Scoreboard: every completed output handshake must match the oldest pending expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h with no pending operation", dout);
      end else begin
        check("dout", {32'h0, dout}, {32'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic wait_valid(input string name, input int lat);
    int cyc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(name, 64'(cyc), 64'(lat));
  endtask

  // Caller guarantees the DUT is idle and the task starts 1 time unit after a rising edge.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sa, input logic sb, input logic up, input logic [W-1:0] exp);
    A = a; B = b; sign_a = sa; sign_b = sb; upper = up;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    sb_q.push_back(exp);
    #1;
    in_valid = 1'b0;
    A = ~a; B = ~b; sign_a = ~sa; sign_b = ~sb; upper = ~up;
    check({name, "_busy_in_ready"}, {63'h0, in_ready}, 64'h0);
    wait_valid({name, "_latency"}, exp_lat(b, sb));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb, e1, e2;
    logic rsa, rsb, rup;

    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001};
    vecs[2]  = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 1'b0, 32'hFFFFFFEB};
    vecs[3]  = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[4]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000};
    vecs[5]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000};
    vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h00000001};
    vecs[8]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 32'h0000000F};
    vecs[9]  = '{32'h00003039, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000};
    vecs[10] = '{32'hFFFFFFFA, 32'hFFFFFFF9, 1'b1, 1'b1, 1'b0, 32'h0000002A};
    vecs[11] = '{32'hFFFFFFFA, 32'hFFFFFFF9, 1'b1, 1'b1, 1'b1, 32'h00000000};

    rst = 1'b0;
    A = '0; B = '0; sign_a = 1'b0; sign_b = 1'b0; upper = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;

    #12;
    check("reset_dout", {32'h0, dout}, 64'h0);
    check("reset_out_valid", {63'h0, out_valid}, 64'h0);
    check("reset_in_ready", {63'h0, in_ready}, 64'h1);

    // Release reset and start on the very next edge.
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb,
             vecs[i].up, vecs[i].exp);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      rsa = 1'($urandom_range(0, 1)); rsb = 1'($urandom_range(0, 1)); rup = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), ra, rb, rsa, rsb, rup, model(ra, rb, rsa, rsb, rup));
    end

    // Consumer stall followed by a same-edge release and back-to-back accept.
    e1 = model(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1);
    A = 32'h12345678; B = 32'h9ABCDEF0; sign_a = 1'b0; sign_b = 1'b0; upper = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    sb_q.push_back(e1);
    #1;
    in_valid = 1'b0;
    wait_valid("stall_latency", exp_lat(32'h9ABCDEF0, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", {63'h0, out_valid}, 64'h1);
      check("stall_dout", {32'h0, dout}, {32'h0, e1});
      check("stall_in_ready", {63'h0, in_ready}, 64'h0);
    end
    e2 = model(32'hFFFF0001, 32'h00000123, 1'b1, 1'b0, 1'b0);
    A = 32'hFFFF0001; B = 32'h00000123; sign_a = 1'b1; sign_b = 1'b0; upper = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("b2b_in_ready", {63'h0, in_ready}, 64'h1);
    @(posedge clk);
    sb_q.push_back(e2);
    #1;
    in_valid = 1'b0;
    check("b2b_out_valid_low", {63'h0, out_valid}, 64'h0);
    check("b2b_busy_in_ready", {63'h0, in_ready}, 64'h0);
    wait_valid("b2b_latency", exp_lat(32'h00000123, 1'b0));
    @(posedge clk);
    #1;

    // Reset in the middle of an operation must drop it silently.
    A = 32'h00000003; B = 32'hFFFFFFFF; sign_a = 1'b0; sign_b = 1'b0; upper = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_dout", {32'h0, dout}, 64'h0);
    check("abort_out_valid", {63'h0, out_valid}, 64'h0);
    check("abort_in_ready", {63'h0, in_ready}, 64'h1);
    repeat (2) @(posedge clk);
    #1;
    check("abort_hold_out_valid", {63'h0, out_valid}, 64'h0);
    rst = 1'b1;
    run_op("after_reset", 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 32'h0000000F);
    run_op("after_reset_b0", 32'h00000009, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 64'(sb_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
- REQ-001 SHALL have parameter WIDTH, default 32, operand and result-word width; legal values are 2 and above.
- REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
- REQ-004 SHALL have ports A and B, input, WIDTH, multiplicand and multiplier.
- REQ-005 SHALL have ports sign_a and sign_b, input, 1 each; 1 treats that operand as two's complement, 0 as unsigned.
- REQ-006 SHALL have port upper, input, 1; 1 returns the product MSB half, 0 returns the LSB half.
- REQ-007 SHALL have port in_valid, input, 1, operand request.
- REQ-008 SHALL have port in_ready, output, 1, block can accept.
- REQ-009 SHALL have port dout, output, WIDTH, selected product half.
- REQ-010 SHALL have port out_valid, output, 1, dout holds a result.
- REQ-011 SHALL have port out_ready, input, 1, consumer takes the result.

Function
- REQ-012 SHALL implement FSM IDLE/BUSY/DONE.
- REQ-013 SHALL accept on a clk edge where in_valid and in_ready are both high, latching A, B, sign_a, sign_b and upper; later input changes have no effect.
- REQ-014 SHALL drive in_ready high in IDLE, high in DONE only while out_ready is high, and low in BUSY.
- REQ-015 SHALL take magnitudes at accept: an operand is negated when its sign flag is 1 and its MSB is 1; the most-negative value yields magnitude 2^(WIDTH-1).
- REQ-016 SHALL process one multiplier bit per BUSY cycle into a 2*WIDTH unsigned accumulator (shift-add).
- REQ-017 SHALL, on the final BUSY edge, negate the 2*WIDTH product when exactly one operand was negative, register the half chosen by the latched upper into dout, and go to DONE.
- REQ-018 SHALL make out_valid high exactly WIDTH cycles after the accept edge when early termination is absent.
- REQ-019 SHALL hold dout and out_valid stable while out_valid is high and out_ready is low.
- REQ-020 SHALL, in DONE with out_ready high: go to BUSY when in_valid is also high (back-to-back accept, same edge); otherwise go to IDLE with out_valid low.
- REQ-021 SHALL keep dout at its last value in IDLE and BUSY.
- REQ-022 SHALL size the iteration counter to hold WIDTH without wrap; the counter reloads to 0 on every accept.

Reset
- REQ-023 SHALL, while rst is low: set FSM to IDLE, out_valid 0, dout 0, and accumulator, counter and latched operands to 0, regardless of clk.
- REQ-024 SHALL abort any in-progress operation on reset without emitting a result.
- REQ-025 SHALL drive in_ready 1 while rst is low.
- REQ-026 SHALL accept an operation on the first clk edge after rst deasserts.

Configuration
- REQ-027 SHALL support macro MUL_ITER_EARLY_TERM_EN; when defined, BUSY ends on the edge where all unprocessed multiplier-magnitude bits are zero.
- REQ-028 SHALL, with the macro defined, give latency = index of the highest set bit of the multiplier magnitude + 1, minimum 1 cycle (B=0 gives 1).
- REQ-029 SHALL, without the macro, always run WIDTH BUSY cycles; results are identical either way.

Verification (WIDTH=32)
- REQ-030 SHALL test unsigned 0xFFFFFFFF*0xFFFFFFFF: upper=1 gives 0xFFFFFFFE, upper=0 gives 0x00000001; without macro, out_valid exactly 32 cycles after accept.
- REQ-031 SHALL test signed*signed A=0xFFFFFFFD, B=7: upper=0 gives 0xFFFFFFEB, upper=1 gives 0xFFFFFFFF.
- REQ-032 SHALL test signed*signed 0x80000000*0x80000000: upper gives 0x40000000, lower gives 0x00000000.
- REQ-033 SHALL test mixed sign_a=1, sign_b=0, A=0xFFFFFFFF, B=0xFFFFFFFF: upper gives 0xFFFFFFFF, lower gives 0x00000001.
- REQ-034 SHALL test out_ready low 10 cycles after a result: dout and out_valid held, in_ready low; then out_ready and in_valid high together: new operation accepted the same edge, out_valid low next cycle.
- REQ-035 SHALL test rst low 10 cycles into BUSY: dout 0, out_valid 0, in_ready 1; with the macro, A=3, B=5 gives dout 15 after 3 cycles, and B=0 gives dout 0 after 1 cycle.
